// File: rtl/uart_tx.sv
// uart_tx: UART serializer; start bit, LSB-first data, optional parity and 1-2 stop bits, paced by s_tick
module uart_tx #(
  parameter int NB_DATA    = 8,
  parameter int S_TICK     = 16,
  parameter int NB_STOP    = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_tick,
  input  logic               tx_start,
  input  logic [NB_DATA-1:0] data_in,
  output logic               tx,
  output logic               tx_busy,
  output logic               tx_done_tick
);
  localparam int TW = $clog2(S_TICK);
  localparam int BC = NB_DATA > NB_STOP ? NB_DATA : NB_STOP;
  localparam int BW = BC > 1 ? $clog2(BC) : 1;
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  logic [2:0]         state, state_n;
  logic [TW-1:0]      tick_cnt, tick_n;
  logic [BW-1:0]      bit_cnt, bit_n;
  logic [NB_DATA-1:0] shift_reg, shift_n;
  logic               par_bit, par_n, tx_n, bit_end, last_bit;
  always_comb begin
    bit_end  = state != IDLE && s_tick && tick_cnt == TW'(S_TICK - 1);
    last_bit = state == STOP ? bit_cnt == BW'(NB_STOP - 1) : bit_cnt == BW'(NB_DATA - 1);
    state_n  = state;
    tick_n   = tick_cnt;
    bit_n    = bit_cnt;
    shift_n  = shift_reg;
    par_n    = par_bit;
    if (state == IDLE && tx_start) begin
      state_n = START;
      tick_n  = '0;
      shift_n = data_in;
      par_n   = ^data_in ^ (PARITY_ODD != 0);
    end else if (state != IDLE && s_tick)
      tick_n = bit_end ? '0 : tick_cnt + 1'b1;
    if (bit_end)
      case (state)
        START: begin
          state_n = DATA;
          bit_n   = '0;
        end
        DATA: begin
          shift_n = shift_reg >> 1;
          bit_n   = last_bit ? '0 : bit_cnt + 1'b1;
          state_n = last_bit ? (PARITY_EN != 0 ? PARITY : STOP) : DATA;
        end
        PARITY: begin
          state_n = STOP;
          bit_n   = '0;
        end
        STOP: begin
          bit_n   = last_bit ? '0 : bit_cnt + 1'b1;
          state_n = last_bit ? IDLE : STOP;
        end
        default: state_n = IDLE;
      endcase
    // line value is registered from the next state so tx never glitches
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : state_n == PARITY ? par_n : 1'b1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick_n;
      bit_cnt   <= bit_n;
      shift_reg <= shift_n;
      par_bit   <= par_n;
      tx        <= tx_n;
      tx_busy   <= state_n != IDLE;
    end
  end
  assign tx_done_tick = bit_end && state == STOP && last_bit;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of four uart_tx configurations against a tick-counting frame model
module tb_uart_tx;
  logic       clk = 1'b0, reset = 1'b0, s_tick = 1'b0, tx_start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx_v[4], busy_v[4], done_v[4];
  int         checks = 0, errors = 0, div = 1, cnt = 0;

  always #5 clk = ~clk;

  uart_tx u0 (.clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .data_in(data_in),
              .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done_tick(done_v[0]));
  uart_tx #(.PARITY_EN(1)) u1 (.clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .data_in(data_in),
              .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done_tick(done_v[1]));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (.clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .data_in(data_in),
              .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done_tick(done_v[2]));
  uart_tx #(.NB_STOP(2)) u3 (.clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start), .data_in(data_in),
              .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done_tick(done_v[3]));

  function automatic int pen(input int d);
    return (d == 1 || d == 2) ? 1 : 0;
  endfunction

  function automatic int flen(input int d);
    return (9 + pen(d) + (d == 3 ? 2 : 1)) * 16;
  endfunction

  function automatic logic [11:0] frame(input int d, input logic [7:0] b);
    logic [11:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = b;
    if (pen(d) != 0) f[9] = ^b ^ (d == 2);
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    cnt++;
    s_tick = (cnt % div == 0);
    #1;
  endtask

  task automatic start(input logic [7:0] b);
    tx_start = 1'b1;
    data_in  = b;
    cyc();
    tx_start = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] b, input bit poke);
    logic [11:0] f[4], rx[4];
    int t, lim, idx;
    t = 0;
    lim = 177 * div + 2;
    for (int d = 0; d < 4; d++) begin
      f[d] = frame(d, b);
      rx[d] = '1;
    end
    start(b);
    for (int k = 0; k < lim; k++) begin
      idx = t / 16;
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("tx d%0d b%02h k%0d", d, b, k), tx_v[d], idx < 12 ? f[d][idx] : 1'b1);
        chk($sformatf("busy d%0d b%02h k%0d", d, b, k), busy_v[d], t < flen(d));
        chk($sformatf("done d%0d b%02h k%0d", d, b, k), done_v[d], s_tick && t == flen(d) - 1);
        if (t % 16 == 8 && idx < 12) rx[d][idx] = tx_v[d];
      end
      if (poke) begin
        tx_start = (k == 50 || k == 159);
        data_in  = 8'hFF;
      end
      t += s_tick ? 1 : 0;
      cyc();
    end
    tx_start = 1'b0;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rx data d%0d", d), rx[d][8:1], b);
      chk($sformatf("rx frame d%0d", d), rx[d], f[d]);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy_v[0] | busy_v[1] | busy_v[2] | busy_v[3]) && n < 1000) begin
      cyc();
      n++;
    end
    chk("idle timeout", n < 1000, 1'b1);
  endtask

  initial begin
    int n;
    repeat (3) cyc();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst tx d%0d", d), tx_v[d], 1'b1);
      chk($sformatf("rst busy d%0d", d), busy_v[d], 1'b0);
      chk($sformatf("rst done d%0d", d), done_v[d], 1'b0);
    end
    reset = 1'b1;
    repeat (2) cyc();
    run_frame(8'h55, 1'b0);
    run_frame(8'h07, 1'b0);
    div = 4;
    run_frame(8'hA3, 1'b0);
    div = 1;
    cyc();
    run_frame(8'hA3, 1'b1);
    start(8'hA3);
    n = 0;
    while (!done_v[0] && n < 300) begin
      cyc();
      n++;
    end
    chk("done0 offset", n, 159);
    cyc();
    chk("b2b idle tx", tx_v[0], 1'b1);
    chk("b2b idle busy", busy_v[0], 1'b0);
    tx_start = 1'b1;
    data_in  = 8'h3C;
    cyc();
    tx_start = 1'b0;
    chk("b2b start tx", tx_v[0], 1'b0);
    chk("b2b start busy", busy_v[0], 1'b1);
    chk("b2b parity dut stop", tx_v[1], 1'b1);
    chk("b2b parity dut busy", busy_v[1], 1'b1);
    wait_idle();
    start(8'hA3);
    repeat (69) cyc();
    chk("pre-rst bit3 d0", tx_v[0], 1'b0);
    chk("pre-rst bit3 d3", tx_v[3], 1'b0);
    #2 reset = 1'b0;
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("async rst tx d%0d", d), tx_v[d], 1'b1);
      chk($sformatf("async rst busy d%0d", d), busy_v[d], 1'b0);
      chk($sformatf("async rst done d%0d", d), done_v[d], 1'b0);
    end
    repeat (3) begin
      cyc();
      chk("held rst done", done_v[0] | done_v[1] | done_v[2] | done_v[3], 1'b0);
      chk("held rst tx", tx_v[0] & tx_v[1] & tx_v[2] & tx_v[3], 1'b1);
    end
    reset = 1'b1;
    cyc();
    run_frame(8'h3C, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter for the UART link; the transmit-side counterpart to the board's UART receiver.
- Accepts a parallel byte from the host-side logic via a start strobe.
- Shifts the byte out LSB-first as a standard frame: start bit, data, optional parity, 1 or 2 stop bits.
- Paced by the shared baud-rate generator's s_tick enable; sits between the interface/ALU control logic and the TX pin.

Parameters:
- NB_DATA, 8, data bits per frame.
- S_TICK, 16, s_tick pulses per bit period (must be >= 2).
- NB_STOP, 1, stop bits per frame (legal values 1 or 2).
- PARITY_EN, 0, 1 = insert a parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1 (0 = even, 1 = odd).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- s_tick  input  1  one-clk-wide baud enable from the baud generator.
- tx_start  input  1  request to send data_in; sampled every clk.
- data_in  input  NB_DATA  byte to send; captured on acceptance.
- tx  output  1  serial line, idle high, registered.
- tx_busy  output  1  high from the cycle after acceptance until return to IDLE.
- tx_done_tick  output  1  one-clk pulse at end of the last stop bit.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, tx=1, tx_busy=0, tx_done_tick=0.
  - Tick counter, bit counter and shift register cleared.
  - Reset mid-frame aborts the frame immediately; no done pulse.
- States: IDLE, START, DATA, PARITY, STOP. tx is driven from a register, so there are no glitches.
- IDLE:
  - tx=1.
  - tx_start=1 is accepted: data_in is latched into the shift register, tick counter=0, next state START.
  - On the next clk: tx=0 and tx_busy=1 (1-clk latency from acceptance to the start edge).
- Bit timing:
  - Every state except IDLE counts s_tick pulses only; clk cycles without s_tick hold all state.
  - A bit ends on the s_tick where tick_count == S_TICK-1; tick_count then resets to 0.
  - Tick counter width is clog2(S_TICK).
- START: tx=0 for S_TICK ticks, then go to DATA with bit counter=0.
- DATA:
  - tx = shift_reg[0].
  - At the end of each bit, shift right and increment the bit counter.
  - After bit NB_DATA-1, go to PARITY if PARITY_EN else STOP.
- PARITY:
  - tx = XOR of the latched data, inverted when PARITY_ODD=1.
  - Computed from the latched copy, not from data_in.
  - S_TICK ticks, then STOP.
- STOP:
  - tx=1 for NB_STOP*S_TICK ticks; the stop-bit counter is reused.
  - On the final tick: tx_done_tick=1 for exactly that clk, next state IDLE.
  - tx_busy falls on the following clk.
- Handshake rules:
  - tx_start is ignored whenever state != IDLE, including the tx_done_tick cycle.
  - A new frame can be accepted on the first IDLE cycle; back-to-back frames are separated by exactly 1 clk of idle-high.
  - data_in changes after acceptance have no effect on the current frame.
- s_tick asserted in the same clk as acceptance is not counted; counting starts from the first s_tick after entry to START.
- Frame length: (1 + NB_DATA + PARITY_EN + NB_STOP) * S_TICK s_tick pulses.

Test Plan:
- Default params, s_tick every clk, tx_start with data_in=0x55:
  - tx = 0,1,0,1,0,1,0,1,0,1, each held 16 clk.
  - tx_done_tick single pulse 160 ticks after the start edge; tx_busy low the next clk.
- PARITY_EN=1, data_in=0x07:
  - PARITY_ODD=0 → parity bit 1.
  - PARITY_ODD=1 → parity bit 0.
  - Frame = 11 bit times; verify with a loopback into the UART receiver, which must report 0x07.
- NB_STOP=2, data_in=0xA3, s_tick every 4th clk:
  - Each bit lasts 64 clk; stop high for 128 clk; tx_done_tick at 11*16 ticks.
  - No state advance on non-tick clks.
- Handshake, data_in=0xA3 accepted:
  - Then pulse tx_start with data_in=0xFF mid-DATA and in the tx_done_tick cycle.
  - Both requests are ignored; the serialized byte is 0xA3.
  - A tx_start 1 clk after done starts a new frame with tx low 1 clk later.
- Reset: drive reset=0 during DATA bit 3 (async, mid-clk):
  - tx=1 and tx_busy=0 immediately; no tx_done_tick.
  - After release, a new 0x3C frame transmits correctly.
